// File: rtl/hazard_unit_mdu_pkg.sv
// Shared definitions for the hazard unit and its MDU scoreboard.
//   FWD_*      : ALU operand forward-select encodings (ForwardAE/ForwardBE).
//   AW_DEFAULT : default register-address width.
//   CNT_BITS   : width of the MDU latency down-counter (holds MDU_LAT up to 15).
package hazard_unit_mdu_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int CNT_BITS   = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_unit_mdu_scoreboard.sv
// mdu_scoreboard: tracks the single multiply/divide op in flight.
// Ports:
//   clk, rst            : clock, async active-high reset
//   issue, issue_dst    : accept a new MDU op and its destination register
//   rs_d, rt_d          : decode source registers
//   uses_rs_d, uses_rt_d: decode instruction really reads Rs / Rt
//   dst_d, rf_we_d      : decode destination and register-file write enable
//   mdu_d               : decode instruction is itself an MDU op
//   mdu_we, mdu_dst     : result write strobe and destination
//   busy                : an op is pending
//   late                : pending op is at least two cycles from writeback
//   raw, waw            : decode hazards against the pending destination
module mdu_scoreboard
  import hazard_unit_mdu_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [AW-1:0] issue_dst,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          uses_rs_d,
  input  logic          uses_rt_d,
  input  logic [AW-1:0] dst_d,
  input  logic          rf_we_d,
  input  logic          mdu_d,
  output logic          mdu_we,
  output logic [AW-1:0] mdu_dst,
  output logic          busy,
  output logic          late,
  output logic          raw,
  output logic          waw
);

  localparam logic [CNT_BITS-1:0] LAT_INIT = CNT_BITS'(MDU_LAT);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_TWO  = CNT_BITS'(2);

  logic                pending_q, pending_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [AW-1:0]       mdu_dst_q, mdu_dst_d;

  // Issue wins over countdown so a new op can start in the same cycle the
  // previous one writes back (cnt==1).
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    mdu_dst_d = mdu_dst_q;
    if (issue) begin
      cnt_d     = LAT_INIT;
      mdu_dst_d = issue_dst;
      pending_d = 1'b1;
    end else if (pending_q) begin
      cnt_d     = cnt_q - CNT_ONE;
      pending_d = (cnt_q != CNT_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
      mdu_dst_q <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      mdu_dst_q <= mdu_dst_d;
    end
  end

  // Register file is write-then-read, so the final (cnt==1) cycle needs no stall.
  assign late    = pending_q & (cnt_q >= CNT_TWO);
  assign mdu_we  = pending_q & (cnt_q == CNT_ONE);
  assign mdu_dst = mdu_dst_q;
  assign busy    = pending_q;

  assign raw = late & (mdu_dst_q != '0) &
               ((uses_rs_d & (rs_d == mdu_dst_q)) | (uses_rt_d & (rt_d == mdu_dst_q)));

  // A younger non-MDU write to the same register must not land before the MDU result.
  assign waw = late & rf_we_d & ~mdu_d & (dst_d == mdu_dst_q) & (dst_d != '0);

endmodule

// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: 5-stage pipeline hazard/forwarding unit with a one-entry
// multiply/divide scoreboard and a saturating stall-cycle counter.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   RsD/RtD/UsesRsD/UsesRtD        : decode sources and read qualifiers
//   DstD/RFWED/MduD                : decode destination, write enable, MDU op
//   BranchD/BranchTakenD/JumpD     : decode control flow
//   RsE/RtE/RFAE/RFWEE/MtoRFSelE   : execute-stage operands and destination
//   RFAM/RFWEM/MtoRFSelM           : memory-stage destination
//   RFAW/RFWEW                     : writeback destination
//   StallF/StallD/FlushD/FlushE    : pipeline control
//   ForwardAD/BD, ForwardAE/BE     : forwarding selects
//   MduWE/MduDst/MduBusy           : MDU writeback port and busy flag
//   StallCount                     : saturating count of stalled cycles
module hazard_unit_mdu
  import hazard_unit_mdu_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RsD,
  input  logic [AW-1:0]    RtD,
  input  logic             UsesRsD,
  input  logic             UsesRtD,
  input  logic [AW-1:0]    DstD,
  input  logic             RFWED,
  input  logic             BranchD,
  input  logic             BranchTakenD,
  input  logic             JumpD,
  input  logic             MduD,
  input  logic [AW-1:0]    RsE,
  input  logic [AW-1:0]    RtE,
  input  logic [AW-1:0]    RFAE,
  input  logic             RFWEE,
  input  logic             MtoRFSelE,
  input  logic [AW-1:0]    RFAM,
  input  logic             RFWEM,
  input  logic             MtoRFSelM,
  input  logic [AW-1:0]    RFAW,
  input  logic             RFWEW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduWE,
  output logic [AW-1:0]    MduDst,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCount
);

  logic rs_e, rt_e, rs_m, rt_m;
  logic lw_stall, br_stall, str_stall, stall;
  logic mdu_late, mdu_raw, mdu_waw, mdu_issue;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Execute-stage forwarding: M is younger than W, so it takes priority.
  always_comb begin
    ForwardAE = FWD_RF;
    if ((RsE != '0) && RFWEM && (RsE == RFAM))      ForwardAE = FWD_M;
    else if ((RsE != '0) && RFWEW && (RsE == RFAW)) ForwardAE = FWD_W;

    ForwardBE = FWD_RF;
    if ((RtE != '0) && RFWEM && (RtE == RFAM))      ForwardBE = FWD_M;
    else if ((RtE != '0) && RFWEW && (RtE == RFAW)) ForwardBE = FWD_W;
  end

  assign ForwardAD = (RsD != '0) & RFWEM & (RsD == RFAM);
  assign ForwardBD = (RtD != '0) & RFWEM & (RtD == RFAM);

  // Decode reads that depend on an older instruction still in E or M.
  assign rs_e = UsesRsD & (RsD != '0) & (RsD == RFAE);
  assign rt_e = UsesRtD & (RtD != '0) & (RtD == RFAE);
  assign rs_m = UsesRsD & (RsD != '0) & (RsD == RFAM);
  assign rt_m = UsesRtD & (RtD != '0) & (RtD == RFAM);

  assign lw_stall = MtoRFSelE & (rs_e | rt_e);
  // The branch comparator sits in decode; an E result or an M load is not yet forwardable.
  assign br_stall = BranchD & ((RFWEE & (rs_e | rt_e)) | (MtoRFSelM & (rs_m | rt_m)));
  assign str_stall = MduD & mdu_late;

  assign stall     = lw_stall | br_stall | mdu_raw | mdu_waw | str_stall;
  assign mdu_issue = MduD & ~stall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  // A stalled branch/jump redirects only once its operands resolve.
  assign FlushD = (JumpD | (BranchD & BranchTakenD)) & ~stall;

  mdu_scoreboard #(
    .AW      (AW),
    .MDU_LAT (MDU_LAT)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue     (mdu_issue),
    .issue_dst (DstD),
    .rs_d      (RsD),
    .rt_d      (RtD),
    .uses_rs_d (UsesRsD),
    .uses_rt_d (UsesRtD),
    .dst_d     (DstD),
    .rf_we_d   (RFWED),
    .mdu_d     (MduD),
    .mdu_we    (MduWE),
    .mdu_dst   (MduDst),
    .busy      (MduBusy),
    .late      (mdu_late),
    .raw       (mdu_raw),
    .waw       (mdu_waw)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mdu.sv
module tb_hazard_unit_mdu;

  localparam int AW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] RsD, RtD, DstD, RsE, RtE, RFAE, RFAM, RFAW;
  logic UsesRsD, UsesRtD, RFWED, BranchD, BranchTakenD, JumpD, MduD;
  logic RFWEE, MtoRFSelE, RFWEM, MtoRFSelM, RFWEW;
  logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic MduWE, MduBusy;
  logic [AW-1:0] MduDst;
  logic [CW-1:0] StallCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit_mdu #(.AW(AW), .MDU_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
    .DstD(DstD), .RFWED(RFWED), .BranchD(BranchD), .BranchTakenD(BranchTakenD),
    .JumpD(JumpD), .MduD(MduD),
    .RsE(RsE), .RtE(RtE), .RFAE(RFAE), .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE),
    .RFAM(RFAM), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM),
    .RFAW(RFAW), .RFWEW(RFWEW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduWE(MduWE), .MduDst(MduDst), .MduBusy(MduBusy), .StallCount(StallCount)
  );

  typedef struct {
    logic [AW-1:0] rsd, rtd, rse, rte, rfae, rfam, rfaw;
    logic usesrs, usesrt, branchd, takend, jumpd;
    logic rfwee, mtoe, rfwem, mtom, rfwew;
    logic x_stall, x_flushd, x_fad, x_fbd;
    logic [1:0] x_fae, x_fbe;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    RsD = '0; RtD = '0; DstD = '0; RsE = '0; RtE = '0; RFAE = '0; RFAM = '0; RFAW = '0;
    UsesRsD = 0; UsesRtD = 0; RFWED = 0; BranchD = 0; BranchTakenD = 0; JumpD = 0; MduD = 0;
    RFWEE = 0; MtoRFSelE = 0; RFWEM = 0; MtoRFSelM = 0; RFWEW = 0;
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();

    for (int i = 0; i < 14; i++) vecs[i] = '{default: '0};
    // forwarding from M to both ALU operands
    vecs[0].rse = 3; vecs[0].rte = 3; vecs[0].rfam = 3; vecs[0].rfaw = 3;
    vecs[0].rfwem = 1; vecs[0].rfwew = 1; vecs[0].x_fae = 2'b10; vecs[0].x_fbe = 2'b10;
    // M not writing: fall back to W
    vecs[1] = vecs[0]; vecs[1].rfwem = 0; vecs[1].x_fae = 2'b01; vecs[1].x_fbe = 2'b01;
    // register 0 never forwarded
    vecs[2] = vecs[0]; vecs[2].rse = 0; vecs[2].x_fae = 2'b00;
    // decode-stage forwarding for the branch comparator
    vecs[3].rsd = 4; vecs[3].rtd = 6; vecs[3].rfam = 4; vecs[3].rfwem = 1; vecs[3].x_fad = 1;
    vecs[4].rsd = 0; vecs[4].rfam = 0; vecs[4].rfwem = 1;
    // load-use
    vecs[5].mtoe = 1; vecs[5].rfae = 5; vecs[5].rtd = 5; vecs[5].usesrt = 1; vecs[5].x_stall = 1;
    vecs[6] = vecs[5]; vecs[6].usesrt = 0; vecs[6].x_stall = 0;
    // ALU producer in E with a non-branch consumer: no stall
    vecs[7].rsd = 5; vecs[7].usesrs = 1; vecs[7].rfae = 5; vecs[7].rfwee = 1;
    // taken branch waiting on an E result
    vecs[8].branchd = 1; vecs[8].takend = 1; vecs[8].rfwee = 1; vecs[8].rfae = 2;
    vecs[8].rsd = 2; vecs[8].usesrs = 1; vecs[8].x_stall = 1;
    // same branch resolved
    vecs[9].branchd = 1; vecs[9].takend = 1; vecs[9].x_flushd = 1;
    vecs[10].jumpd = 1; vecs[10].x_flushd = 1;
    // branch waiting on a load in M
    vecs[11].branchd = 1; vecs[11].mtom = 1; vecs[11].rfam = 9; vecs[11].rtd = 9;
    vecs[11].usesrt = 1; vecs[11].rfwem = 1; vecs[11].x_stall = 1; vecs[11].x_fbd = 1;
    // not-taken branch, no hazard
    vecs[12].branchd = 1;
    // load writing r0 never stalls
    vecs[13].usesrs = 1; vecs[13].mtoe = 1;

    // reset state
    #12;
    chk("rst_stall", StallD, 0);
    chk("rst_busy", MduBusy, 0);
    chk("rst_mduwe", MduWE, 0);
    chk("rst_mdudst", MduDst, 0);
    chk("rst_cnt", StallCount, 0);
    step();
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      clear_in();
      RsD = vecs[i].rsd; RtD = vecs[i].rtd; RsE = vecs[i].rse; RtE = vecs[i].rte;
      RFAE = vecs[i].rfae; RFAM = vecs[i].rfam; RFAW = vecs[i].rfaw;
      UsesRsD = vecs[i].usesrs; UsesRtD = vecs[i].usesrt;
      BranchD = vecs[i].branchd; BranchTakenD = vecs[i].takend; JumpD = vecs[i].jumpd;
      RFWEE = vecs[i].rfwee; MtoRFSelE = vecs[i].mtoe; RFWEM = vecs[i].rfwem;
      MtoRFSelM = vecs[i].mtom; RFWEW = vecs[i].rfwew;
      #3;
      chk($sformatf("v%0d_stalld", i), StallD, vecs[i].x_stall);
      chk($sformatf("v%0d_stallf", i), StallF, vecs[i].x_stall);
      chk($sformatf("v%0d_flushe", i), FlushE, vecs[i].x_stall);
      chk($sformatf("v%0d_flushd", i), FlushD, vecs[i].x_flushd);
      chk($sformatf("v%0d_fad", i), ForwardAD, vecs[i].x_fad);
      chk($sformatf("v%0d_fbd", i), ForwardBD, vecs[i].x_fbd);
      chk($sformatf("v%0d_fae", i), ForwardAE, vecs[i].x_fae);
      chk($sformatf("v%0d_fbe", i), ForwardBE, vecs[i].x_fbe);
      step();
    end

    // MDU RAW: stall 3 cycles, write-back strobe on the 4th, no stall then
    clear_in();
    MduD = 1; DstD = 7;
    #3;
    chk("raw_issue_stall", StallD, 0);
    step();
    clear_in();
    RsD = 7; UsesRsD = 1;
    for (int c = 1; c <= 4; c++) begin
      #3;
      chk($sformatf("raw_c%0d_stall", c), StallD, (c < 4) ? 8'd1 : 8'd0);
      chk($sformatf("raw_c%0d_we", c), MduWE, (c == 4) ? 8'd1 : 8'd0);
      chk($sformatf("raw_c%0d_busy", c), MduBusy, 1);
      step();
    end
    #3;
    chk("raw_done_busy", MduBusy, 0);
    chk("raw_done_we", MduWE, 0);
    step();

    // structural back-to-back, then WAW against the second op
    clear_in();
    MduD = 1; DstD = 7;
    step();
    DstD = 8;
    for (int c = 1; c <= 4; c++) begin
      #3;
      chk($sformatf("str_c%0d_stall", c), StallD, (c < 4) ? 8'd1 : 8'd0);
      chk($sformatf("str_c%0d_we", c), MduWE, (c == 4) ? 8'd1 : 8'd0);
      if (c == 4) chk("str_c4_dst", MduDst, 7);
      step();
    end
    clear_in();
    RFWED = 1; DstD = 8;
    #3;
    chk("waw_dst", MduDst, 8);
    chk("waw_busy", MduBusy, 1);
    chk("waw_stall", StallD, 1);
    DstD = 5;
    #1;
    chk("waw_other_stall", StallD, 0);
    clear_in();
    for (int c = 0; c < 5; c++) step();
    chk("drain_busy", MduBusy, 0);

    // MDU with r0 destination occupies the unit but raises no hazard
    MduD = 1; DstD = 0;
    step();
    clear_in();
    UsesRsD = 1; RFWED = 1;
    #3;
    chk("r0_busy", MduBusy, 1);
    chk("r0_stall", StallD, 0);
    clear_in();
    for (int c = 0; c < 5; c++) step();

    // reset while cnt==2
    MduD = 1; DstD = 7;
    step();
    clear_in();
    RsD = 7; UsesRsD = 1;
    step();
    step();
    #3;
    chk("mid_busy_pre", MduBusy, 1);
    chk("mid_stall_pre", StallD, 1);
    rst = 1;
    #1;
    chk("mid_busy", MduBusy, 0);
    chk("mid_we", MduWE, 0);
    chk("mid_cnt", StallCount, 0);
    chk("mid_stall", StallD, 0);
    clear_in();
    step();
    rst = 0;

    // stall counter saturates at all-ones
    MtoRFSelE = 1; RFAE = 5; RtD = 5; UsesRtD = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("sat_k%0d", k), StallCount, (k < 7) ? 8'(k) : 8'd7);
    end
    clear_in();
    step();
    chk("sat_hold", StallCount, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
